// File: rtl/cascade_counter_pkg.sv
// Shared defaults and legality checks for the cascaded modulo counter.
// Latency: n/a (constants and elaboration-time helpers only).
// Backpressure: n/a.
package cascade_counter_pkg;

    localparam int DEF_W      = 4;
    localparam int DEF_MOD_LO = 12;
    localparam int DEF_MOD_HI = 15;

    // Legal ranges: a stage needs at least two states, and modulus-1 must fit in W bits.
    localparam int MOD_MIN = 2;
    localparam int W_MIN   = 1;
    localparam int W_MAX   = 30;

    function automatic bit mod_is_legal(input int w, input int m);
        return (w >= W_MIN) && (w <= W_MAX) && (m >= MOD_MIN) && (m <= (1 << w));
    endfunction

endpackage

// File: rtl/mod_cnt_stage.sv
// One modulo-MOD up/down count stage with clear, clamped load and carry chaining.
// Latency: count updates one edge after the request; o_cout is combinational.
// Backpressure: none; i_cin is a one-cycle step request, never stalled.
module mod_cnt_stage
    import cascade_counter_pkg::*;
#(
    parameter int W   = DEF_W,
    parameter int MOD = DEF_MOD_LO
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_up,
    input  logic         i_cin,
    output logic [W-1:0] o_cnt,
    output logic         o_cout
);

    localparam logic [W-1:0] MAX   = W'(MOD - 1);
    localparam logic [W:0]   MOD_X = (W + 1)'(MOD);

    if (!mod_is_legal(W, MOD)) begin : g_bad_param
        $error("mod_cnt_stage: illegal W=%0d / MOD=%0d", W, MOD);
    end

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_next;
    logic [W-1:0] w_load_sat;
    logic         w_at_term;

    // Terminal value depends on direction: top of range going up, zero going down.
    assign w_at_term  = i_up ? (r_cnt == MAX) : (r_cnt == '0);
    assign o_cout     = i_cin & w_at_term;
    // Out-of-range load values saturate so an illegal state is never entered.
    assign w_load_sat = ({1'b0, i_load_val} >= MOD_X) ? MAX : i_load_val;
    assign o_cnt      = r_cnt;

    // Next value for a single step in the current direction, wrapping at the ends.
    always_comb begin
        w_next = r_cnt;
        if (i_up) begin
            w_next = w_at_term ? '0 : r_cnt + W'(1);
        end else begin
            w_next = w_at_term ? MAX : r_cnt - W'(1);
        end
    end

    // Stage register: clear beats load beats step.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= w_load_sat;
        end else if (i_cin) begin
            r_cnt <= w_next;
        end
    end

endmodule

// File: rtl/cascade_counter.sv
// Two-stage cascaded modulo counter (MOD_LO x MOD_HI) with terminal counts and a wrap pulse.
// Latency: counts and o_wrap update one edge after the request; o_tc_* are combinational.
// Backpressure: none; i_en steps every edge it is high.
module cascade_counter
    import cascade_counter_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int MOD_LO = DEF_MOD_LO,
    parameter int MOD_HI = DEF_MOD_HI
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic         i_up,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_lo,
    input  logic [W-1:0] i_load_hi,
    output logic [W-1:0] o_cnt_lo,
    output logic [W-1:0] o_cnt_hi,
    output logic         o_tc_lo,
    output logic         o_tc_hi,
    output logic         o_wrap
);

    if (!mod_is_legal(W, MOD_LO) || !mod_is_legal(W, MOD_HI)) begin : g_bad_param
        $error("cascade_counter: illegal W=%0d MOD_LO=%0d MOD_HI=%0d", W, MOD_LO, MOD_HI);
    end

    logic w_step;
    logic w_tc_lo;
    logic w_tc_hi;
    logic r_wrap;

    // A count step only happens when neither clear nor load claims the edge.
    assign w_step = i_en & ~i_clr & ~i_load;

    mod_cnt_stage #(.W(W), .MOD(MOD_LO)) u_lo (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (i_clr),
        .i_load     (i_load),
        .i_load_val (i_load_lo),
        .i_up       (i_up),
        .i_cin      (w_step),
        .o_cnt      (o_cnt_lo),
        .o_cout     (w_tc_lo)
    );

    // High stage only advances on the low stage's carry/borrow.
    mod_cnt_stage #(.W(W), .MOD(MOD_HI)) u_hi (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (i_clr),
        .i_load     (i_load),
        .i_load_val (i_load_hi),
        .i_up       (i_up),
        .i_cin      (w_tc_lo),
        .o_cnt      (o_cnt_hi),
        .o_cout     (w_tc_hi)
    );

    // Wrap pulse: registered copy of the full-chain terminal count (already low under clr/load).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_tc_hi;
        end
    end

    assign o_tc_lo = w_tc_lo;
    assign o_tc_hi = w_tc_hi;
    assign o_wrap  = r_wrap;

endmodule

// File: tb/tb_cascade_counter.sv
// Randomized and directed bench for cascade_counter against a linear-index reference model.
// Instance a: defaults (W=4, 12x15); instance b: W=3, 8x5.
module tb_cascade_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en   [2];
    logic       up   [2];
    logic       clr  [2];
    logic       load [2];
    logic [3:0] llo  [2];
    logic [3:0] lhi  [2];

    logic [3:0] a_lo, a_hi;
    logic       a_tcl, a_tch, a_wr;
    logic [2:0] b_lo, b_hi;
    logic       b_tcl, b_tch, b_wr;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: whole chain as one index in [0, ml*mh).
    int ml  [2] = '{12, 8};
    int mh  [2] = '{15, 5};
    int idx [2] = '{0, 0};
    int wr_pulses [2] = '{0, 0};

    always #5 clk = ~clk;

    cascade_counter dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en[0]), .i_up(up[0]), .i_clr(clr[0]),
        .i_load(load[0]), .i_load_lo(llo[0]), .i_load_hi(lhi[0]),
        .o_cnt_lo(a_lo), .o_cnt_hi(a_hi), .o_tc_lo(a_tcl), .o_tc_hi(a_tch), .o_wrap(a_wr)
    );

    cascade_counter #(.W(3), .MOD_LO(8), .MOD_HI(5)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en[1]), .i_up(up[1]), .i_clr(clr[1]),
        .i_load(load[1]), .i_load_lo(llo[1][2:0]), .i_load_hi(lhi[1][2:0]),
        .o_cnt_lo(b_lo), .o_cnt_hi(b_hi), .o_tc_lo(b_tcl), .o_tc_hi(b_tch), .o_wrap(b_wr)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int clampv(input int v, input int m);
        return (v >= m) ? m - 1 : v;
    endfunction

    function automatic int stepping(input int d);
        return (en[d] && !clr[d] && !load[d]) ? 1 : 0;
    endfunction

    function automatic int exp_tcl(input int d);
        int lo = idx[d] % ml[d];
        return (stepping(d) != 0 && (up[d] ? lo == ml[d] - 1 : lo == 0)) ? 1 : 0;
    endfunction

    function automatic int exp_tch(input int d);
        int p = ml[d] * mh[d];
        return (stepping(d) != 0 && (up[d] ? idx[d] == p - 1 : idx[d] == 0)) ? 1 : 0;
    endfunction

    task automatic obs(input int d, output int lo, output int hi, output int tcl,
                       output int tch, output int wr);
        if (d == 0) begin
            lo = int'(a_lo); hi = int'(a_hi); tcl = int'(a_tcl); tch = int'(a_tch); wr = int'(a_wr);
        end else begin
            lo = int'(b_lo); hi = int'(b_hi); tcl = int'(b_tcl); tch = int'(b_tch); wr = int'(b_wr);
        end
    endtask

    task automatic model_update(input int d);
        int p = ml[d] * mh[d];
        if (clr[d]) idx[d] = 0;
        else if (load[d]) idx[d] = clampv(int'(lhi[d]), mh[d]) * ml[d] + clampv(int'(llo[d]), ml[d]);
        else if (en[d]) idx[d] = up[d] ? (idx[d] + 1) % p : (idx[d] + p - 1) % p;
    endtask

    // One clock: check combinational terminal counts, then registered state after the edge.
    task automatic step();
        int lo, hi, tcl, tch, wr;
        int e_wr [2];
        #1;
        for (int d = 0; d < 2; d++) begin
            obs(d, lo, hi, tcl, tch, wr);
            chk($sformatf("tc_lo%0d", d), tcl, exp_tcl(d));
            chk($sformatf("tc_hi%0d", d), tch, exp_tch(d));
            e_wr[d] = exp_tch(d);
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            model_update(d);
            obs(d, lo, hi, tcl, tch, wr);
            chk($sformatf("cnt_lo%0d", d), lo, idx[d] % ml[d]);
            chk($sformatf("cnt_hi%0d", d), hi, idx[d] / ml[d]);
            chk($sformatf("wrap%0d", d), wr, e_wr[d]);
            wr_pulses[d] += wr;
        end
    endtask

    task automatic idle();
        for (int d = 0; d < 2; d++) begin
            en[d] = 1'b0; up[d] = 1'b1; clr[d] = 1'b0; load[d] = 1'b0;
            llo[d] = 4'd0; lhi[d] = 4'd0;
        end
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #12;
        chk("rst_lo_a", int'(a_lo), 0);
        chk("rst_hi_a", int'(a_hi), 0);
        chk("rst_wr_a", int'(a_wr), 0);
        chk("rst_lo_b", int'(b_lo), 0);
        chk("rst_hi_b", int'(b_hi), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load 7/3, then assert reset between edges.
        load[0] = 1'b1; llo[0] = 4'd7; lhi[0] = 4'd3;
        step();
        idle();
        chk("ld73_lo", int'(a_lo), 7);
        chk("ld73_hi", int'(a_hi), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_lo", int'(a_lo), 0);
        chk("async_rst_hi", int'(a_hi), 0);
        chk("async_rst_wr", int'(a_wr), 0);
        idx[0] = 0; idx[1] = 0;
        #1;
        rst_n = 1'b1;

        // Full up period at defaults.
        en[0] = 1'b1; up[0] = 1'b1; wr_pulses[0] = 0;
        repeat (180) step();
        chk("up_period_wraps", wr_pulses[0], 1);
        chk("up_period_lo", int'(a_lo), 0);
        chk("up_period_hi", int'(a_hi), 0);

        // Down from 0/0.
        up[0] = 1'b0;
        step();
        chk("dn1_lo", int'(a_lo), 11);
        chk("dn1_hi", int'(a_hi), 14);
        chk("dn1_wrap", int'(a_wr), 1);
        step();
        chk("dn2_lo", int'(a_lo), 10);
        chk("dn2_hi", int'(a_hi), 14);

        // Load clamp then one up step carrying into the high stage.
        idle();
        load[0] = 1'b1; llo[0] = 4'd13; lhi[0] = 4'd2;
        step();
        chk("clamp_lo", int'(a_lo), 11);
        chk("clamp_hi", int'(a_hi), 2);
        load[0] = 1'b0; en[0] = 1'b1; up[0] = 1'b1;
        step();
        chk("clamp_step_lo", int'(a_lo), 0);
        chk("clamp_step_hi", int'(a_hi), 3);

        // clr beats load; then hold with en low.
        clr[0] = 1'b1; load[0] = 1'b1; llo[0] = 4'd5; lhi[0] = 4'd5;
        step();
        chk("prio_lo", int'(a_lo), 0);
        chk("prio_hi", int'(a_hi), 0);
        idle();
        repeat (5) step();
        chk("hold_lo", int'(a_lo), 0);
        chk("hold_hi", int'(a_hi), 0);
        chk("hold_tc_lo", int'(a_tcl), 0);

        // Narrow instance: full periods both directions.
        en[1] = 1'b1; up[1] = 1'b1; wr_pulses[1] = 0;
        repeat (40) step();
        chk("b_up_wraps", wr_pulses[1], 1);
        chk("b_up_lo", int'(b_lo), 0);
        chk("b_up_hi", int'(b_hi), 0);
        up[1] = 1'b0; wr_pulses[1] = 0;
        repeat (40) step();
        chk("b_dn_wraps", wr_pulses[1], 1);
        chk("b_dn_lo", int'(b_lo), 0);
        chk("b_dn_hi", int'(b_hi), 0);

        // Random traffic on both instances, including direction flips mid-count.
        repeat (600) begin
            for (int d = 0; d < 2; d++) begin
                clr[d]  = ($urandom % 25) == 0;
                load[d] = ($urandom % 15) == 0;
                en[d]   = ($urandom % 5) != 0;
                up[d]   = ($urandom % 8) != 0 ? up[d] : ~up[d];
                llo[d]  = 4'($urandom_range(0, d == 0 ? 15 : 7));
                lhi[d]  = 4'($urandom_range(0, d == 0 ? 15 : 7));
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
